// File: rtl/controle_execucao_pkg.sv
// Shared definitions for controle_execucao: decoder enable codes and the
// execution FSM state encoding.
package pkg_controle;

  localparam logic [1:0] EN_WAIT_IN  = 2'd0;
  localparam logic [1:0] EN_RUN      = 2'd1;
  localparam logic [1:0] EN_WAIT_OUT = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_WAIT_OUT = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  // Code 3 is not issued by the decoder but is tolerated as a run request.
  function automatic logic is_run_code(input logic [1:0] code);
    return (code == EN_RUN) || (code == 2'd3);
  endfunction

endpackage

// File: rtl/controle_execucao_debouncer.sv
// debouncer_botao: accepts a new level on din only after DEBOUNCE_CYCLES
// consecutive samples that differ from the currently accepted level.
module debouncer_botao #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;

  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    if (din == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_next = din;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      level_reg <= RESET_LEVEL;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
    end
  end

  assign dout = level_reg;

endmodule

// File: rtl/controle_execucao.sv
// controle_execucao: execution-enable FSM, push-button press detector and
// preemption quantum timer. Define CONTROLE_DEBOUNCE_EN to insert debouncer_botao.
module controle_execucao
  import pkg_controle::*;
#(
  parameter int TIMER_W         = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         enable_clock,
  input  logic               halt,
  input  logic               set_clock,
  input  logic [TIMER_W-1:0] timer_value,
  input  logic               get_interruption,
  input  logic               button,
  output logic               cpu_enable,
  output logic               wait_in,
  output logic               wait_out,
  output logic               halted,
  output logic               timer_irq
);

`ifdef CONTROLE_DEBOUNCE_EN
  localparam bit DEBOUNCE_ON = 1'b1;
`else
  localparam bit DEBOUNCE_ON = 1'b0;
`endif

  // Button path: synchronizer, optional debouncer, falling-edge detector.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic                   level;
  logic                   level_d_reg;
  logic                   press_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg    <= '1;
      level_d_reg <= 1'b1;
      press_reg   <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], button};
      level_d_reg <= level;
      press_reg   <= level_d_reg & ~level;
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_ON && (DEBOUNCE_CYCLES > 0)) begin : g_debounce
      debouncer_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
      ) u_debouncer (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (sync_out),
        .dout   (level)
      );
    end else begin : g_bypass
      assign level = sync_out;
    end
  endgenerate

  // Execution FSM
  state_t state_reg, state_next;
  logic   enable_raw;
  logic   wait_in_reg, wait_out_reg, halted_reg;

  always_comb begin
    state_next = state_reg;
    enable_raw = 1'b0;
    unique case (state_reg)
      ST_RUN: begin
        enable_raw = ~halt & is_run_code(enable_clock);
        if (halt)
          state_next = ST_HALTED;
        else if (enable_clock == EN_WAIT_IN)
          state_next = ST_WAIT_IN;
        else if (enable_clock == EN_WAIT_OUT)
          state_next = ST_WAIT_OUT;
      end
      ST_WAIT_IN, ST_WAIT_OUT: begin
        enable_raw = press_reg;
        if (press_reg)
          state_next = ST_RUN;
      end
      ST_HALTED: begin
        enable_raw = 1'b0;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Reset must also mask the combinational enable while it is held.
  assign cpu_enable = enable_raw & reset_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_RUN;
      wait_in_reg  <= 1'b0;
      wait_out_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_in_reg  <= (state_next == ST_WAIT_IN);
      wait_out_reg <= (state_next == ST_WAIT_OUT);
      halted_reg   <= (state_next == ST_HALTED);
    end
  end

  assign wait_in  = wait_in_reg;
  assign wait_out = wait_out_reg;
  assign halted   = halted_reg;

  // Quantum timer: advances, loads and acknowledges only in enabled cycles.
  logic [TIMER_W-1:0] count_reg, count_next;
  logic               armed_reg, armed_next;
  logic               irq_reg, irq_next;
  logic               expire;

  always_comb begin
    count_next = count_reg;
    armed_next = armed_reg;
    irq_next   = irq_reg;
    expire     = 1'b0;
    if (cpu_enable) begin
      if (set_clock) begin
        count_next = timer_value;
        armed_next = |timer_value;
      end else if (armed_reg && (count_reg != '0)) begin
        count_next = count_reg - TIMER_W'(1);
        if (count_reg == TIMER_W'(1)) begin
          expire     = 1'b1;
          armed_next = 1'b0;
        end
      end
      if (expire)
        irq_next = 1'b1;
      else if (get_interruption)
        irq_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      armed_reg <= armed_next;
      irq_reg   <= irq_next;
    end
  end

  assign timer_irq = irq_reg;

endmodule

// File: tb/tb_controle_execucao.sv
// Scoreboard bench for controle_execucao: directed scenarios plus random
// traffic, checked cycle by cycle against a behavioural model.
module tb_controle_execucao;

  localparam int TW = 16;
  localparam int DB = 4;
  localparam int SS = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    enable_clock = 2'd1;
  logic          halt = 1'b0;
  logic          set_clock = 1'b0;
  logic [TW-1:0] timer_value = '0;
  logic          get_interruption = 1'b0;
  logic          button = 1'b1;
  logic          cpu_enable, wait_in, wait_out, halted, timer_irq;

  controle_execucao #(
    .TIMER_W        (TW),
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (SS)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable_clock    (enable_clock),
    .halt            (halt),
    .set_clock       (set_clock),
    .timer_value     (timer_value),
    .get_interruption(get_interruption),
    .button          (button),
    .cpu_enable      (cpu_enable),
    .wait_in         (wait_in),
    .wait_out        (wait_out),
    .halted          (halted),
    .timer_irq       (timer_irq)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic en;
    logic wi;
    logic wo;
    logic hl;
    logic irq;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Model state: button history, accepted level history, mode and quantum.
  bit bh[$];
  bit lh[$];
  bit m_dlvl = 1'b1;
  int m_wait = 0;      // 0 none, 1 waiting for IN, 2 waiting for OUT
  bit m_halt = 1'b0;
  int m_left = 0;      // instructions left in the quantum, 0 = inactive
  bit m_irq  = 1'b0;

  function automatic bit samp(input int m);
    if (m - SS < 0) return 1'b1;
    return bh[m - SS];
  endfunction

  task automatic cycle(input bit rn, input bit [1:0] ec, input bit h, input bit sc,
                       input bit [TW-1:0] tv, input bit gi, input bit b, input string name);
    int   n;
    bit   lv;
    bit   press;
    bit   en;
    exp_t e;
`ifdef CONTROLE_DEBOUNCE_EN
    bit   flip;
`endif
    @(posedge clock);
    #1;
    reset_n          = rn;
    enable_clock     = ec;
    halt             = h;
    set_clock        = sc;
    timer_value      = tv;
    get_interruption = gi;
    button           = b;

    n = bh.size();
    bh.push_back(b);
`ifdef CONTROLE_DEBOUNCE_EN
    lv   = m_dlvl;
    flip = 1'b1;
    for (int k = 0; k < DB; k++)
      if (samp(n - k) == m_dlvl) flip = 1'b0;
    if (flip) m_dlvl = ~m_dlvl;
    if (!rn) m_dlvl = 1'b1;
`else
    lv = samp(n);
`endif
    lh.push_back(lv);
    press = (n >= 2) && lh[n-2] && !lh[n-1];

    if (!rn) begin
      e      = '0;
      m_wait = 0;
      m_halt = 1'b0;
      m_left = 0;
      m_irq  = 1'b0;
    end else begin
      if (m_halt)           en = 1'b0;
      else if (m_wait != 0) en = press;
      else                  en = !h && (ec == 2'd1 || ec == 2'd3);
      e = '{en: en, wi: (m_wait == 1), wo: (m_wait == 2), hl: m_halt, irq: m_irq};

      if (!m_halt) begin
        if (m_wait != 0) begin
          if (press) m_wait = 0;
        end else if (h)         m_halt = 1'b1;
        else if (ec == 2'd0)    m_wait = 1;
        else if (ec == 2'd2)    m_wait = 2;
      end

      if (en) begin
        bit fire;
        fire = 1'b0;
        if (sc) begin
          m_left = int'(tv);
        end else if (m_left > 0) begin
          m_left = m_left - 1;
          fire   = (m_left == 0);
        end
        if (fire)    m_irq = 1'b1;
        else if (gi) m_irq = 1'b0;
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(name);
  endtask

  task automatic run_cycles(input int cnt, input bit b, input string name);
    for (int i = 0; i < cnt; i++) cycle(1, 2'd1, 0, 0, '0, 0, b, name);
  endtask

  task automatic do_reset(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(0, 2'd1, 0, 0, '0, 0, 1, "reset_held");
    cycle(1, 2'd1, 0, 0, '0, 0, 1, "reset_release");
  endtask

  // Monitor: one comparison per presented cycle, away from the active edge.
  exp_t  mon_exp, mon_act;
  string mon_tag;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = '{en: cpu_enable, wi: wait_in, wo: wait_out, hl: halted, irq: timer_irq};
      n_vec++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s @%0t: en/wi/wo/hl/irq got %b required %b",
                 mon_tag, $time, mon_act, mon_exp);
      end
    end
  end

  initial begin
    bit          rb;
    int          hold;
    bit [1:0]    rec;
    bit          rh, rsc, rgi;
    bit [TW-1:0] rtv;

    do_reset(3);
    run_cycles(5, 1, "run");

    cycle(1, 2'd0, 0, 0, '0, 0, 1, "enter_wait_in");
    for (int i = 0; i < 49; i++) cycle(1, 2'd0, 0, 0, '0, 0, 1, "wait_in_idle");
    run_cycles(20, 0, "wait_in_press");
    run_cycles(15, 1, "wait_in_release");

    cycle(1, 2'd2, 0, 0, '0, 0, 1, "enter_wait_out");
    run_cycles(2, 0, "glitch");
    run_cycles(12, 1, "post_glitch");
    run_cycles(10, 0, "wait_out_press");
    run_cycles(15, 1, "wait_out_release");

    cycle(1, 2'd1, 0, 1, TW'(3), 0, 1, "load3");
    run_cycles(5, 1, "count3");
    cycle(1, 2'd1, 0, 0, '0, 1, 1, "ack_irq");
    run_cycles(2, 1, "after_ack");
    cycle(1, 2'd1, 0, 1, '0, 0, 1, "load0");
    run_cycles(10, 1, "load0_idle");

    cycle(1, 2'd1, 0, 1, TW'(2), 0, 1, "load2");
    run_cycles(1, 1, "count_to_1");
    cycle(1, 2'd1, 0, 1, TW'(5), 0, 1, "reload_at_1");
    run_cycles(7, 1, "count5");
    cycle(1, 2'd1, 0, 0, '0, 1, 1, "ack5");

    cycle(1, 2'd1, 0, 1, TW'(4), 0, 1, "load4");
    run_cycles(1, 1, "count4");
    cycle(1, 2'd0, 0, 0, '0, 0, 1, "wait_mid_count");
    for (int i = 0; i < 10; i++) cycle(1, 2'd0, 0, 0, '0, 0, 1, "frozen");
    run_cycles(8, 0, "resume_press");
    run_cycles(15, 1, "resume_count");

    for (int blk = 0; blk < 6; blk++) begin
      rb   = 1'b1;
      hold = $urandom_range(1, 12);
      for (int i = 0; i < 80; i++) begin
        rec = ($urandom_range(0, 9) < 6) ? 2'd1 : 2'($urandom_range(0, 3));
        rh  = ($urandom_range(0, 199) == 0);
        rsc = ($urandom_range(0, 9) == 0);
        rtv = TW'($urandom_range(0, 7));
        rgi = ($urandom_range(0, 7) == 0);
        if (hold == 0) begin
          rb   = ~rb;
          hold = $urandom_range(1, 12);
        end
        hold--;
        cycle(1, rec, rh, rsc, rtv, rgi, rb, "random");
      end
      run_cycles(12, 1, "random_settle");
      do_reset(2);
    end

    cycle(1, 2'd0, 1, 0, '0, 0, 1, "halt_priority");
    for (int i = 0; i < 5; i++) cycle(1, 2'd0, 0, 0, '0, 0, 1, "halted_idle");
    run_cycles(10, 0, "halted_press");
    run_cycles(12, 1, "halted_release");
    do_reset(2);
    run_cycles(5, 1, "run_after_halt");

    @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
